// File: rtl/sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper.
// Holds the FSM state encoding and vector-space constants.
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

endpackage

// File: rtl/settle_timer.sv
// Hold-time counter: counts 0..SETTLE_CYCLES while enabled,
// pulses expire on the terminal count and restarts.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = ($clog2(SETTLE_CYCLES + 1) < 1) ?
                        1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 3-bit vectors onto two circuits, samples both outputs
// after a settle time and reports per-minterm mismatches.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       G1,
    input  logic       G2,
    output logic       busy,
    output logic       done,
    output logic [7:0] table1,
    output logic [7:0] table2,
    output logic [7:0] mismatch,
    output logic       match
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SWEEP = ST_SWEEP;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             expire;
    logic             go;
    logic [7:0]       t1_next;
    logic [7:0]       t2_next;

    assign go = start && ((state == IDLE) || (state == DONE));

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (go),
        .enable (state == SWEEP),
        .expire (expire)
    );

    // Tables with the current sample merged in, so the final
    // compare sees the vector-7 result in the same edge.
    always_comb begin
        t1_next      = table1;
        t2_next      = table2;
        t1_next[idx] = G1;
        t2_next[idx] = G2;
    end

    assign {a, b, c} = idx;
    assign busy      = (state == SWEEP);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            table1   <= '0;
            table2   <= '0;
            mismatch <= '0;
            match    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SWEEP;
                        idx      <= '0;
                        table1   <= '0;
                        table2   <= '0;
                        mismatch <= '0;
                        match    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SWEEP: begin
                    if (expire) begin
                        table1 <= t1_next;
                        table2 <= t2_next;
                        idx    <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state    <= DONE;
                            mismatch <= t1_next ^ t2_next;
                            match    <= (t1_next == t2_next);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper at three settle settings.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;
    logic diff;

    logic       start2, a2, b2, c2, g12, g22, busy2, done2, match2;
    logic [7:0] t12, t22, mm2;
    logic       start0, a0, b0, c0, g10, g20, busy0, done0, match0;
    logic [7:0] t10, t20, mm0;
    logic       start3, a3, b3, c3, g13, g23, busy3, done3, match3;
    logic [7:0] t13, t23, mm3;

    int passed;
    int total;
    int sel;
    int lat;

    logic [2:0] abc_s;
    logic       busy_s;
    logic       done_s;

    function automatic logic f(input logic x, input logic y, input logic z);
        return (~x & ~y & z) | (x & ~y & z) | (x & y & ~z) | (x & y & z);
    endfunction

    assign g12 = f(a2, b2, c2);
    assign g22 = f(a2, b2, c2) ^ (diff & a2 & b2 & ~c2);
    assign g10 = f(a0, b0, c0);
    assign g20 = f(a0, b0, c0);
    assign g13 = f(a3, b3, c3);
    assign g23 = f(a3, b3, c3);

    truth_table_sweeper #(.SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a(a2), .b(b2), .c(c2), .G1(g12), .G2(g22),
        .busy(busy2), .done(done2), .table1(t12), .table2(t22),
        .mismatch(mm2), .match(match2)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a(a0), .b(b0), .c(c0), .G1(g10), .G2(g20),
        .busy(busy0), .done(done0), .table1(t10), .table2(t20),
        .mismatch(mm0), .match(match0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a(a3), .b(b3), .c(c3), .G1(g13), .G2(g23),
        .busy(busy3), .done(done3), .table1(t13), .table2(t23),
        .mismatch(mm3), .match(match3)
    );

    always_comb begin
        abc_s  = {a2, b2, c2};
        busy_s = busy2;
        done_s = done2;
        case (sel)
            0: begin
                abc_s  = {a0, b0, c0};
                busy_s = busy0;
                done_s = done0;
            end
            3: begin
                abc_s  = {a3, b3, c3};
                busy_s = busy3;
                done_s = done3;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Waits for done on u2; lat counts edges after the start edge.
    task automatic wait_done2();
        lat = 0;
        while (!done2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_seq(input int s);
        int hold;
        hold = s + 1;
        sel  = s;
        if (s == 0) start0 = 1'b1;
        else        start3 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        for (int n = 0; n < 8 * hold; n++) begin
            chk($sformatf("seq_s%0d_n%0d", s, n), 32'(abc_s), 32'(n / hold));
            @(negedge clk);
        end
        chk($sformatf("seq_s%0d_done", s), 32'(done_s), 32'd1);
        chk($sformatf("seq_s%0d_busy", s), 32'(busy_s), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        sel    = 2;
        diff   = 1'b0;
        start2 = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs",
                {a2, b2, c2, busy2, done2, match2, t12, t22, mm2}, 32'd0);
        end

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("eq_busy_k1", 32'(busy2), 32'd1);
        chk("eq_abc_k1", 32'({a2, b2, c2}), 32'd0);
        wait_done2();
        chk("eq_latency", 32'(lat), 32'd24);
        chk("eq_busy_at_done", 32'(busy2), 32'd0);
        chk("eq_table1", 32'(t12), 32'hE2);
        chk("eq_table2", 32'(t22), 32'hE2);
        chk("eq_mismatch", 32'(mm2), 32'h00);
        chk("eq_match", 32'(match2), 32'd1);
        @(negedge clk);
        chk("eq_done_pulse", 32'(done2), 32'd0);
        chk("eq_idle_busy", 32'(busy2), 32'd0);
        chk("eq_hold_t1", 32'(t12), 32'hE2);

        diff   = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("diff_match_clr", 32'(match2), 32'd0);
        wait_done2();
        chk("diff_latency", 32'(lat), 32'd24);
        chk("diff_table1", 32'(t12), 32'hE2);
        chk("diff_table2", 32'(t22), 32'hA2);
        chk("diff_mismatch", 32'(mm2), 32'h40);
        chk("diff_match", 32'(match2), 32'd0);
        @(negedge clk);
        diff = 1'b0;

        run_seq(0);
        run_seq(3);
        sel = 2;

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 5 || lat == 9 || lat == 20) start2 = 1'b1;
            if (lat == 6 || lat == 10) start2 = 1'b0;
        end
        chk("busy_start_latency", 32'(lat), 32'd24);
        chk("busy_start_match", 32'(match2), 32'd1);
        @(negedge clk);
        chk("b2b_busy", 32'(busy2), 32'd1);
        chk("b2b_done", 32'(done2), 32'd0);
        chk("b2b_abc", 32'({a2, b2, c2}), 32'd0);
        chk("b2b_tables", {8'h00, t12, t22, mm2}, 32'd0);
        chk("b2b_match", 32'(match2), 32'd0);
        start2 = 1'b0;
        wait_done2();
        chk("b2b_latency", 32'(lat), 32'd24);
        chk("b2b_table1", 32'(t12), 32'hE2);
        chk("b2b_match_end", 32'(match2), 32'd1);
        @(negedge clk);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while ({a2, b2, c2} != 3'd4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_reach_v4", 32'({a2, b2, c2}), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs",
            {a2, b2, c2, busy2, done2, match2, t12, t22, mm2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle_busy", 32'(busy2), 32'd0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done2();
        chk("rst_sweep_latency", 32'(lat), 32'd24);
        chk("rst_sweep_table1", 32'(t12), 32'hE2);
        chk("rst_sweep_table2", 32'(t22), 32'hE2);
        chk("rst_sweep_match", 32'(match2), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
